// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
//
// Built-in self-test sequencer for a single-bit logic gate (NOT/AND/OR/XOR).
// An 8-bit Fibonacci LFSR supplies the stimulus bits a/b. Each vector is held
// for SETTLE idle cycles, after which the gate output is sampled and compared
// against an internal reference of the selected gate function. Mismatches are
// counted (saturating) and pass/fail is reported when the run finishes.
//
// Ports
//   clk      rising-edge clock, single domain
//   rst_n    synchronous active-low reset
//   start    level; starts a run when sampled high in IDLE or DONE
//   mode     gate under test: 0 NOT(a), 1 AND, 2 OR, 3 XOR (latched at start)
//   a_o      stimulus bit a to the gate under test
//   b_o      stimulus bit b to the gate under test (0 for NOT)
//   gate_i   gate-under-test output
//   busy     run in progress
//   done     run finished, results stable
//   pass     valid with done; 1 when no mismatch was seen
//   err_cnt  saturating mismatch count
//   vec_cnt  vectors checked so far in the current run
// -----------------------------------------------------------------------------
module gate_bist_ctrl #(
   parameter int         N_VECTORS = 16,
   parameter int         SETTLE    = 1,
   parameter int         CNT_W     = 8,
   parameter logic [7:0] SEED      = 8'hA5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic             a_o,
   output logic             b_o,
   input  logic             gate_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [7:0]       vec_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE_W,
      CHECK,
      DONE
   } state_t;

   localparam logic [7:0] N_LAST      = 8'(N_VECTORS);
   // Last value of the settle counter; unused when SETTLE is 0 because the
   // FSM then skips SETTLE_W entirely.
   localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   state_t           state;
   logic [7:0]       lfsr;
   logic [1:0]       mode_q;
   logic [3:0]       settle_cnt;
   logic             miss;
   logic [CNT_W-1:0] err_next;

   // Reference behaviour of the gate under test.
   function automatic logic gate_ref(input logic [1:0] m, input logic a,
                                     input logic b);
      logic r;
      case (m)
         2'd0:    r = ~a;
         2'd1:    r = a & b;
         2'd2:    r = a | b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   // x^8+x^6+x^5+x^4+1, shifting left with feedback entering at bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Saturating increment: the counter sticks at all ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic hit);
      return (hit && (c != '1)) ? c + CNT_W'(1) : c;
   endfunction

   assign miss     = (gate_i != gate_ref(mode_q, a_o, b_o));
   assign err_next = sat_inc(err_cnt, miss);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         lfsr       <= SEED;
         mode_q     <= 2'd0;
         settle_cnt <= 4'd0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         vec_cnt    <= 8'd0;
      end else begin
         case (state)
            // Start is only honoured here; a run in flight cannot be aborted.
            IDLE, DONE: begin
               if (start) begin
                  lfsr       <= SEED;
                  err_cnt    <= '0;
                  vec_cnt    <= 8'd0;
                  settle_cnt <= 4'd0;
                  mode_q     <= mode;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  state      <= APPLY;
               end
            end

            // Present the current LFSR bits to the gate.
            APPLY: begin
               a_o        <= lfsr[0];
               b_o        <= (mode_q == 2'd0) ? 1'b0 : lfsr[1];
               settle_cnt <= 4'd0;
               state      <= (SETTLE > 0) ? SETTLE_W : CHECK;
            end

            // Give the external gate path time to settle.
            SETTLE_W: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end

            // Sample gate_i, score it and step to the next vector.
            CHECK: begin
               err_cnt <= err_next;
               vec_cnt <= vec_cnt + 8'd1;
               lfsr    <= lfsr_step(lfsr);
               if ((vec_cnt + 8'd1) == N_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= DONE;
               end else begin
                  state <= APPLY;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_ctrl
//
// Three controller instances with different SETTLE / CNT_W settings, each
// driving its own gate model (selectable function, optional 3-cycle delay).
// Expected run results are computed from the gate rules and queued when a run
// is issued; a negedge monitor pops and compares whenever done rises.
// -----------------------------------------------------------------------------
module tb_gate_bist_ctrl;

   localparam int NV      = 16;
   localparam int SET [3] = '{1, 3, 0};
   localparam int CW  [3] = '{8, 3, 8};
   localparam int DLY [3] = '{0, 3, 3};

   typedef struct {
      int          err;
      bit          exact;
      bit          exp_pass;
      logic [15:0] sa;
      logic [15:0] sb;
      int          period;
      int          lat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [2:0]      start;
   logic [2:0][1:0] mode;
   logic [2:0]      a_o, b_o, gate_i, busy, done, pass;
   logic [7:0]      err0, err2, vec0, vec1, vec2;
   logic [2:0]      err1;
   logic [2:0][2:0] ha, hb;
   int              gsel [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   exp_t        sbq [3][$];
   bit          mon_en = 1'b0;
   int          rise_cyc [3];
   int          last_tr  [3];
   int          min_gap  [3];
   int          pvec     [3];
   bit          pa       [3];
   bit          pbusy    [3];
   bit          pdone    [3];
   logic [15:0] cap_a    [3];
   logic [15:0] cap_b    [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gate_bist_ctrl u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
      .a_o(a_o[0]), .b_o(b_o[0]), .gate_i(gate_i[0]), .busy(busy[0]),
      .done(done[0]), .pass(pass[0]), .err_cnt(err0), .vec_cnt(vec0)
   );

   gate_bist_ctrl #(.SETTLE(3), .CNT_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
      .a_o(a_o[1]), .b_o(b_o[1]), .gate_i(gate_i[1]), .busy(busy[1]),
      .done(done[1]), .pass(pass[1]), .err_cnt(err1), .vec_cnt(vec1)
   );

   gate_bist_ctrl #(.SETTLE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]),
      .a_o(a_o[2]), .b_o(b_o[2]), .gate_i(gate_i[2]), .busy(busy[2]),
      .done(done[2]), .pass(pass[2]), .err_cnt(err2), .vec_cnt(vec2)
   );

   function automatic int err_of(input int g);
      case (g)
         0:       return int'(err0);
         1:       return int'(err1);
         default: return int'(err2);
      endcase
   endfunction

   function automatic int vec_of(input int g);
      case (g)
         0:       return int'(vec0);
         1:       return int'(vec1);
         default: return int'(vec2);
      endcase
   endfunction

   // Gate functions: 0 NOT a, 1 AND, 2 OR, 3 XOR, 4 buffer of a.
   function automatic logic eval(input int sel, input logic a, input logic b);
      case (sel)
         0:       return ~a;
         1:       return a & b;
         2:       return a | b;
         3:       return a ^ b;
         default: return a;
      endcase
   endfunction

   // Gate models; the delayed variant sees a_o/b_o three cycles late.
   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         ha[g] <= {ha[g][1:0], a_o[g]};
         hb[g] <= {hb[g][1:0], b_o[g]};
      end
   end

   always_comb begin
      gate_i = '0;
      for (int g = 0; g < 3; g++) begin
         if (DLY[g] == 0) gate_i[g] = eval(gsel[g], a_o[g], b_o[g]);
         else             gate_i[g] = eval(gsel[g], ha[g][2], hb[g][2]);
      end
   end

   // Whole-run prediction from the gate rules and the LFSR polynomial.
   function automatic exp_t ref_run(input int g, input int md, input int gs);
      exp_t e;
      int   s, cnt, sat, fb;
      logic a, b;
      s   = 'hA5;
      cnt = 0;
      for (int i = 0; i < NV; i++) begin
         a = ((s % 2) == 1);
         b = (md == 0) ? 1'b0 : (((s / 2) % 2) == 1);
         e.sa[i] = a;
         e.sb[i] = b;
         if (eval(gs, a, b) != eval(md, a, b)) cnt++;
         fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
         s  = ((s * 2) % 256) + fb;
      end
      sat        = (1 << CW[g]) - 1;
      e.exact    = (SET[g] >= DLY[g]);
      e.err      = (cnt > sat) ? sat : cnt;
      e.exp_pass = e.exact && (e.err == 0);
      e.period   = SET[g] + 2;
      e.lat      = NV * e.period;
      return e;
   endfunction

   task automatic chk(input string nm, input int g, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s inst=%0d got=%0d expected=%0d", nm, g, act, exp);
      end
   endtask

   // Monitor: tracks stimulus timing and vectors, scores each finished run.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         for (int g = 0; g < 3; g++) begin
            if (busy[g] && !pbusy[g]) begin
               rise_cyc[g] = cyc;
               last_tr[g]  = -1;
               min_gap[g]  = 9999;
               pa[g]       = a_o[g];
               cap_a[g]    = '0;
               cap_b[g]    = '0;
            end else if (busy[g]) begin
               if (a_o[g] != pa[g]) begin
                  if (last_tr[g] >= 0 && (cyc - last_tr[g]) < min_gap[g])
                     min_gap[g] = cyc - last_tr[g];
                  last_tr[g] = cyc;
                  pa[g]      = a_o[g];
               end
               if (pbusy[g]) begin
                  chk("vec_step", g,
                      int'(vec_of(g) == pvec[g] || vec_of(g) == pvec[g] + 1), 1);
               end
            end
            if (vec_of(g) == pvec[g] + 1 && pvec[g] < NV) begin
               cap_a[g][pvec[g]] = a_o[g];
               cap_b[g][pvec[g]] = b_o[g];
            end
            if (done[g] && !pdone[g]) begin
               if (sbq[g].size() == 0) begin
                  chk("unexpected_done", g, 1, 0);
               end else begin
                  e = sbq[g].pop_front();
                  if (e.exact) chk("err_cnt", g, err_of(g), e.err);
                  else         chk("err_nonzero", g, int'(err_of(g) != 0), 1);
                  chk("pass", g, int'(pass[g]), int'(e.exp_pass));
                  chk("vec_cnt", g, vec_of(g), NV);
                  chk("busy_at_done", g, int'(busy[g]), 0);
                  chk("latency", g, cyc - rise_cyc[g], e.lat);
                  chk("a_seq", g, int'(cap_a[g]), int'(e.sa));
                  chk("b_seq", g, int'(cap_b[g]), int'(e.sb));
                  chk("period", g, min_gap[g], e.period);
               end
            end
            pbusy[g] = busy[g];
            pdone[g] = done[g];
            pvec[g]  = vec_of(g);
         end
      end
   end

   task automatic wait_done(input int g, input string nm);
      int k;
      k = 0;
      while (done[g] !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk(nm, g, int'(done[g] === 1'b1), 1);
   endtask

   task automatic do_run(input int g, input int md, input int gs, input bit noise);
      exp_t e;
      int   len;
      mode[g] = 2'(md);
      gsel[g] = gs;
      e = ref_run(g, md, gs);
      sbq[g].push_back(e);
      @(posedge clk); #1 start[g] = 1'b1;
      @(posedge clk); #1 start[g] = 1'b0;
      mode[g] = 2'($urandom_range(0, 3));
      if (noise) begin
         len = NV * (SET[g] + 2) - 4;
         for (int k = 0; k < len; k++) begin
            start[g] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         start[g] = 1'b0;
      end
      wait_done(g, "done_timeout");
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      int   k, md, gs;
      rst_n = 1'b0;
      start = '0;
      mode  = '0;
      for (int g = 0; g < 3; g++) gsel[g] = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("rst_a", g, int'(a_o[g]), 0);
         chk("rst_b", g, int'(b_o[g]), 0);
         chk("rst_busy", g, int'(busy[g]), 0);
         chk("rst_done", g, int'(done[g]), 0);
         chk("rst_pass", g, int'(pass[g]), 0);
         chk("rst_err", g, err_of(g), 0);
         chk("rst_vec", g, vec_of(g), 0);
         pbusy[g] = 1'b0;
         pdone[g] = 1'b0;
         pvec[g]  = 0;
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Matching NOT model twice, then a buffer (always wrong).
      do_run(0, 0, 0, 0);
      do_run(0, 0, 0, 1);
      do_run(0, 0, 4, 0);
      // Matching two-input models, and XOR model against AND.
      do_run(0, 1, 1, 1);
      do_run(0, 2, 2, 1);
      do_run(0, 3, 3, 1);
      do_run(0, 1, 3, 1);
      // Saturating 3-bit counter with SETTLE=3 and delayed gate.
      do_run(1, 0, 4, 0);
      do_run(1, 0, 0, 0);
      // Delayed gate with no settle time.
      do_run(2, 0, 0, 0);

      // Reset in the middle of a run.
      mode[0] = 2'd0;
      gsel[0] = 0;
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      k = 0;
      while (vec0 != 8'd7 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_vec7", 0, int'(vec0), 7);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_a", 0, int'(a_o[0]), 0);
      chk("mid_rst_b", 0, int'(b_o[0]), 0);
      chk("mid_rst_busy", 0, int'(busy[0]), 0);
      chk("mid_rst_done", 0, int'(done[0]), 0);
      chk("mid_rst_pass", 0, int'(pass[0]), 0);
      chk("mid_rst_err", 0, int'(err0), 0);
      chk("mid_rst_vec", 0, int'(vec0), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", 0, int'(busy[0]), 0);
      chk("idle_done", 0, int'(done[0]), 0);
      do_run(0, 0, 0, 0);

      // Start held high: DONE for one cycle, then an identical second run.
      mode[0] = 2'd0;
      gsel[0] = 4;
      e = ref_run(0, 0, 4);
      sbq[0].push_back(e);
      sbq[0].push_back(e);
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1;
      wait_done(0, "held_done1");
      @(posedge clk); #1;
      chk("done_one_cycle", 0, int'(done[0]), 0);
      chk("held_restart_busy", 0, int'(busy[0]), 1);
      chk("held_err_cleared", 0, int'(err0), 0);
      chk("held_vec_cleared", 0, int'(vec0), 0);
      start[0] = 1'b0;
      wait_done(0, "held_done2");
      repeat (2) @(posedge clk);
      #1;

      // Random modes and gate models with start noise during the run.
      for (int r = 0; r < 6; r++) begin
         md = $urandom_range(0, 3);
         gs = ($urandom_range(0, 1) == 1) ? md : $urandom_range(0, 4);
         do_run(0, md, gs, 1);
      end

      for (int g = 0; g < 3; g++) chk("sb_empty", g, sbq[g].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test controller for the single-bit logic-gate datapaths (NOT, AND, OR, XOR).
- Generates pseudo-random stimulus from an 8-bit LFSR and drives it into an external gate under test.
- Waits a programmable settle time, samples the gate output and compares it against an internal reference model.
- Counts mismatches and reports pass/fail.
- Replaces free-running `$random` stimulus with a deterministic, repeatable, synthesizable sequencer that sits beside the gate instance.

## Interface
Parameters:
- N_VECTORS, 16: number of vectors applied per run, 1..255.
- SETTLE, 1: idle cycles between applying a vector and sampling the gate output, 0..15.
- CNT_W, 8: width of the error counter.
- SEED, 8'hA5: LFSR load value at reset and at each start; must be nonzero.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  level; begins a run when sampled high in IDLE or DONE.
- mode  in  2  gate function under test: 0 NOT(a), 1 a AND b, 2 a OR b, 3 a XOR b. Latched at start.
- a_o  out  1  stimulus bit a to the gate under test.
- b_o  out  1  stimulus bit b to the gate under test; held 0 when latched mode = 0.
- gate_i  in  1  gate-under-test output.
- busy  out  1  high from the cycle after start is accepted until the DONE state is entered.
- done  out  1  high while in DONE.
- pass  out  1  valid while done = 1; 1 iff err_cnt = 0.
- err_cnt  out  CNT_W  mismatch count for the current or last run; saturating.
- vec_cnt  out  8  number of vectors checked so far in the current run.

## Operation
- LFSR: 8-bit Fibonacci, shifts left, polynomial x^8+x^6+x^5+x^4+1.
  - Feedback = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3], inserted at bit 0.
  - a = lfsr[0], b = lfsr[1].
- FSM states: IDLE, APPLY, SETTLE_W, CHECK, DONE.
- IDLE or DONE with start=1:
  - Load lfsr=SEED; clear err_cnt, vec_cnt and the settle counter.
  - Latch mode; go to APPLY.
- APPLY: register a_o/b_o from the LFSR (b_o forced 0 for mode 0). Go to SETTLE_W if SETTLE>0, else to CHECK.
- SETTLE_W: count SETTLE cycles, then go to CHECK.
- CHECK:
  - Compute expected = f(mode, a_o, b_o).
  - If gate_i != expected and err_cnt is not all ones, increment err_cnt.
  - Increment vec_cnt; advance the LFSR one step.
  - If vec_cnt+1 = N_VECTORS go to DONE, else go to APPLY.
- DONE: hold a_o, b_o, err_cnt and vec_cnt; done=1, pass=(err_cnt==0). Remain until start=1 or reset.
- start=1 during APPLY, SETTLE_W or CHECK is ignored; a run cannot be aborted except by reset.
- mode changes after start have no effect until the next accepted start.
- err_cnt saturates at 2^CNT_W-1 and never wraps.
- start held high continuously: DONE is occupied for exactly one cycle, then a new identical run begins. The SEED reload makes the stimulus sequence repeat bit-exactly.

## Timing
- Reset (rst_n=0 at a clock edge) puts every output at its reset value on the next edge:
  - state=IDLE, lfsr=SEED.
  - a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0.
- Reset mid-run has the same effect; there is no partial result.
- start accepted at edge T: busy=1 and the first vector appears on a_o/b_o at edge T+2, after the APPLY registration.
- Per-vector period is SETTLE+2 cycles. gate_i is sampled in CHECK, SETTLE+1 cycles after a_o/b_o change.
- gate_i is treated as synchronous/combinational from a_o/b_o. The external gate path must settle within SETTLE+1 clock periods.
- done rises N_VECTORS×(SETTLE+2)+1 cycles after the start edge; busy falls on the same edge.
- err_cnt and vec_cnt update on the CHECK edge and are visible the following cycle.

## Test plan
- Defaults, mode=0, gate_i driven by a NOT-gate model of a_o; start pulsed one cycle at cycle 5 → done=1 at cycle 5+49, pass=1, err_cnt=0, vec_cnt=16. Two runs produce an identical a_o sequence.
- mode=0, gate_i = a_o (buffer, wrong polarity) → err_cnt=16, pass=0. Repeat with CNT_W=3 → err_cnt saturates at 7 and never wraps to 0.
- mode=1/2/3 with matching AND/OR/XOR models → pass=1. XOR model while mode=1 → err_cnt equals the bench-model count of vectors where a|b=1 and the two functions differ; the count must be nonzero.
- SETTLE=3 with the gate model delayed 3 cycles → pass=1. SETTLE=0 with the same 3-cycle-delayed model → err_cnt>0. Per-vector period measured on a_o transitions = 5 and 2 cycles respectively.
- rst_n=0 for one cycle at vector 7 → next cycle all outputs at reset values, state IDLE. A new start then gives vec_cnt=16 and the full SEED sequence from vector 0.
- start toggled during SETTLE_W/CHECK → no restart, vec_cnt monotonic. start held high → DONE lasts exactly one cycle and a second run begins with err_cnt cleared.
